exec_regfile_alu: RTL and testbench

- Register-file plus execute stage of the single-cycle RV64 datapath; merges the register file, ALU-control decoder and 64-bit ALU into one block.
- Takes the fetched instruction, the main-control ALU class, ALUSrc, the immediate and the write-back data.
- Produces register read data, the ALU result and the zero/overflow flags used for branch and memory addressing.

---
 rtl/exec_regfile_alu.sv | 127 ++++++++++++
 tb/tb_exec_regfile_alu.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/exec_regfile_alu.sv
// Register file, ALU-control decode and 64-bit ALU for the single-cycle RV64 datapath.
// Reads and ALU results are combinational; only register writes are clocked.
module exec_regfile_alu #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic [2:0]        alu_class,
    input  logic              alu_src,
    input  logic [XLEN-1:0]   imm,
    input  logic              reg_write,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic [2:0]        alu_sel,
    output logic [XLEN-1:0]   alu_result,
    output logic              alu_zero,
    output logic              alu_overflow
);

    localparam int AW = $clog2(NREGS);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [AW-1:0]   w_rs1;
    logic [AW-1:0]   w_rs2;
    logic [AW-1:0]   w_rd;
    logic [2:0]      w_funct3;
    logic            w_bit30;
    logic            w_unused_instr;
    logic [XLEN-1:0] r_regs [NREGS];
    logic [2:0]      w_alu_sel;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_result;
    logic            w_overflow;

    assign w_rs1    = instruction[19:15];
    assign w_rs2    = instruction[24:20];
    assign w_rd     = instruction[11:7];
    assign w_funct3 = instruction[14:12];
    assign w_bit30  = instruction[30];
    assign w_unused_instr = ^{instruction[31], instruction[29:25], instruction[6:0]};

    // Entry 0 is never written; reads of x0 are forced to zero so it is
    // well defined even before the first reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (reg_write && (w_rd != '0)) begin
            r_regs[w_rd] <= wb_data;
        end
    end

    assign rs1_data = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
    assign rs2_data = (w_rs2 == '0) ? '0 : r_regs[w_rs2];

    always_comb begin
        w_alu_sel = OP_ADD;
        case (alu_class)
            3'b000: w_alu_sel = OP_ADD;
            3'b001: w_alu_sel = OP_SUB;
            3'b010, 3'b011: begin
                case (w_funct3)
                    // Only R-type distinguishes SUB via bit 30; I-type has no SUBI.
                    3'b000:  w_alu_sel = (alu_class == 3'b010 && w_bit30) ? OP_SUB : OP_ADD;
                    3'b111:  w_alu_sel = OP_AND;
                    3'b110:  w_alu_sel = OP_OR;
                    3'b100:  w_alu_sel = OP_XOR;
                    3'b001:  w_alu_sel = OP_SLL;
                    3'b101:  w_alu_sel = OP_SRL;
                    3'b010:  w_alu_sel = OP_SLT;
                    default: w_alu_sel = OP_ADD;
                endcase
            end
            default: w_alu_sel = OP_ADD;
        endcase
    end

    assign alu_sel = w_alu_sel;
    assign w_op_a  = rs1_data;
    assign w_op_b  = alu_src ? imm : rs2_data;
    assign w_sum   = w_op_a + w_op_b;
    assign w_diff  = w_op_a - w_op_b;

    always_comb begin
        w_result   = w_sum;
        w_overflow = 1'b0;
        case (w_alu_sel)
            OP_AND: w_result = w_op_a & w_op_b;
            OP_OR:  w_result = w_op_a | w_op_b;
            OP_ADD: begin
                w_result   = w_sum;
                w_overflow = (w_op_a[XLEN-1] == w_op_b[XLEN-1]) &&
                             (w_sum[XLEN-1] != w_op_a[XLEN-1]);
            end
            OP_XOR: w_result = w_op_a ^ w_op_b;
            OP_SLL: w_result = w_op_a << w_op_b[5:0];
            OP_SRL: w_result = w_op_a >> w_op_b[5:0];
            OP_SUB: begin
                w_result   = w_diff;
                w_overflow = (w_op_a[XLEN-1] != w_op_b[XLEN-1]) &&
                             (w_diff[XLEN-1] != w_op_a[XLEN-1]);
            end
            OP_SLT: w_result = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            default: w_result = w_sum;
        endcase
    end

    assign alu_result   = w_result;
    assign alu_zero     = (w_result == '0);
    assign alu_overflow = w_overflow;

endmodule

// File: tb/tb_exec_regfile_alu.sv
// Directed-vector bench: stimulus pushes hand-computed expectations into a
// queue; a negedge monitor pops and compares whatever the DUT presents.
module tb_exec_regfile_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [2:0]  alu_class;
    logic        alu_src;
    logic [63:0] imm;
    logic        reg_write;
    logic [63:0] wb_data;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [2:0]  alu_sel;
    logic [63:0] alu_result;
    logic        alu_zero;
    logic        alu_overflow;

    typedef struct {
        string       name;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [2:0]  sel;
        logic [63:0] res;
        logic        zero;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    logic chk_valid = 1'b0;
    int   total = 0;
    int   bad   = 0;

    exec_regfile_alu dut (
        .clk          (clk),
        .reset        (reset),
        .instruction  (instruction),
        .alu_class    (alu_class),
        .alu_src      (alu_src),
        .imm          (imm),
        .reg_write    (reg_write),
        .wb_data      (wb_data),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .alu_sel      (alu_sel),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [4:0] rd, input logic [2:0] f3,
                                       input logic b30);
        return {1'b0, b30, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic cmp(input string vec, input string fld, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", vec, fld, act, req);
        end
    endtask

    // Monitor: combinational outputs are settled half a cycle after each vector.
    always @(negedge clk) begin
        if (chk_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL monitor.queue actual=empty required=entry");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                cmp(e.name, "rs1",  rs1_data,            e.rs1);
                cmp(e.name, "rs2",  rs2_data,            e.rs2);
                cmp(e.name, "sel",  {61'd0, alu_sel},    {61'd0, e.sel});
                cmp(e.name, "res",  alu_result,          e.res);
                cmp(e.name, "zero", {63'd0, alu_zero},   {63'd0, e.zero});
                cmp(e.name, "ovf",  {63'd0, alu_overflow}, {63'd0, e.ovf});
                $display("txn %s: rs1=%h rs2=%h sel=%0d res=%h z=%0b v=%0b",
                         e.name, rs1_data, rs2_data, alu_sel, alu_result,
                         alu_zero, alu_overflow);
            end
        end
    end

    task automatic vec(input string nm, input logic [31:0] ins, input logic [2:0] cls,
                       input logic src, input logic [63:0] im, input logic rw,
                       input logic [63:0] wb, input logic rst,
                       input logic [63:0] e_rs1, input logic [63:0] e_rs2,
                       input logic [2:0] e_sel, input logic [63:0] e_res,
                       input logic e_ovf);
        exp_t e;
        @(posedge clk);
        #1;
        instruction = ins;
        alu_class   = cls;
        alu_src     = src;
        imm         = im;
        reg_write   = rw;
        wb_data     = wb;
        reset       = rst;
        e.name = nm;
        e.rs1  = e_rs1;
        e.rs2  = e_rs2;
        e.sel  = e_sel;
        e.res  = e_res;
        e.zero = (e_res == 64'd0);
        e.ovf  = e_ovf;
        exp_q.push_back(e);
        chk_valid = 1'b1;
    endtask

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    initial begin
        reset       = 1'b1;
        instruction = '0;
        alu_class   = '0;
        alu_src     = 1'b0;
        imm         = '0;
        reg_write   = 1'b0;
        wb_data     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        //   name        instr                      cls    src imm     rw wb       rst  rs1   rs2   sel     res                    ovf
        vec("reset_rd",  mk(1, 2, 0, 3'b000, 0),    3'b001, 0, 64'd0,  0, 64'd0,   0,   0,    0,    3'b110, 64'd0,                 0);
        vec("wr_x5",     mk(5, 0, 5, 3'b000, 0),    3'b000, 1, 64'd0,  1, 64'h10,  0,   0,    0,    3'b010, 64'd0,                 0);
        vec("wr_x6",     mk(5, 6, 6, 3'b000, 0),    3'b000, 0, 64'd0,  1, 64'h3,   0,   64'h10, 0,  3'b010, 64'h10,                0);
        vec("sub_r",     mk(5, 6, 0, 3'b000, 1),    3'b010, 0, 64'd0,  0, 64'd0,   0,   64'h10, 64'h3, 3'b110, 64'hD,             0);
        vec("wr_x0",     mk(0, 5, 0, 3'b000, 0),    3'b000, 0, 64'd0,  1, 64'hFFFF, 0,  0,    64'h10, 3'b010, 64'h10,              0);
        vec("rd_x0",     mk(0, 0, 0, 3'b110, 0),    3'b010, 0, 64'd0,  0, 64'd0,   0,   0,    0,    3'b001, 64'd0,                 0);
        vec("wr_x7",     mk(0, 0, 7, 3'b000, 0),    3'b000, 1, 64'd0,  1, MAXP,    0,   0,    0,    3'b010, 64'd0,                 0);
        vec("wr_x8",     mk(0, 0, 8, 3'b000, 0),    3'b000, 1, 64'd0,  1, MINN,    0,   0,    0,    3'b010, 64'd0,                 0);
        vec("add_ovf",   mk(7, 0, 0, 3'b000, 0),    3'b011, 1, 64'd1,  0, 64'd0,   0,   MAXP, 0,    3'b010, MINN,                  1);
        vec("and_noovf", mk(7, 0, 0, 3'b111, 0),    3'b011, 1, 64'd1,  0, 64'd0,   0,   MAXP, 0,    3'b000, 64'd1,                 0);
        vec("addi_b30",  mk(5, 0, 0, 3'b000, 1),    3'b011, 1, '1,     0, 64'd0,   0,   64'h10, 0,  3'b010, 64'hF,                 0);
        vec("slt_r",     mk(6, 5, 0, 3'b010, 0),    3'b010, 0, 64'd0,  0, 64'd0,   0,   64'h3, 64'h10, 3'b111, 64'd1,             0);
        vec("slti_neg",  mk(5, 0, 0, 3'b010, 0),    3'b011, 1, '1,     0, 64'd0,   0,   64'h10, 0,  3'b111, 64'd0,                 0);
        vec("slli",      mk(6, 0, 0, 3'b001, 0),    3'b011, 1, 64'h41, 0, 64'd0,   0,   64'h3, 0,   3'b100, 64'h6,                 0);
        vec("srli_b30",  mk(8, 0, 0, 3'b101, 1),    3'b011, 1, 64'd4,  0, 64'd0,   0,   MINN, 0,    3'b101, 64'h0800_0000_0000_0000, 0);
        vec("xor_r",     mk(5, 6, 0, 3'b100, 0),    3'b010, 0, 64'd0,  0, 64'd0,   0,   64'h10, 64'h3, 3'b011, 64'h13,            0);
        vec("sub_ovf",   mk(8, 6, 0, 3'b000, 0),    3'b001, 0, 64'd0,  0, 64'd0,   0,   MINN, 64'h3, 3'b110, 64'h7FFF_FFFF_FFFF_FFFD, 1);
        vec("cls_101",   mk(5, 6, 0, 3'b000, 1),    3'b101, 0, 64'd0,  0, 64'd0,   0,   64'h10, 64'h3, 3'b010, 64'h13,            0);
        vec("r_f3_011",  mk(5, 6, 0, 3'b011, 0),    3'b010, 0, 64'd0,  0, 64'd0,   0,   64'h10, 64'h3, 3'b010, 64'h13,            0);
        vec("rst_wr_x7", mk(7, 5, 7, 3'b000, 0),    3'b000, 1, 64'd0,  1, 64'h55,  1,   MAXP, 64'h10, 3'b010, MAXP,               0);
        vec("post_rst",  mk(7, 5, 0, 3'b000, 0),    3'b000, 1, 64'd0,  0, 64'd0,   0,   0,    0,    3'b010, 64'd0,                 0);

        @(posedge clk);
        #1;
        chk_valid = 1'b0;
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard.drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
